// File: rtl/rx_control_fifo.sv
// rx_control_fifo: receive-side word buffer between the UART receiver and the
// consumer. Captures every RX_Done_Sig word into a DEPTH-entry register FIFO,
// presents the head word with a valid/read handshake, and reports occupancy,
// almost-full and a sticky overflow flag.
module rx_control_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RX_Done_Sig,
  input  logic [DATA_W-1:0]             RX_Data,
  input  logic                          RX_Read_Sig,
  input  logic                          RX_Ovf_Clr,
  output logic                          RX_En_Sig,
  output logic [DATA_W-1:0]             RX_Data_Out,
  output logic [$clog2(DEPTH):0]        RX_Count,
  output logic                          RX_Full_Sig,
  output logic                          RX_Afull_Sig,
  output logic                          RX_Ovf_Sig
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              full;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_evt;

  // Handshake decode: a read frees a slot, so a full FIFO still takes a word
  // when the consumer pops in the same cycle; an empty FIFO never bypasses.
  always_comb begin
    full    = (cnt_q == CNT_W'(DEPTH));
    empty   = (cnt_q == '0);
    rd_acc  = RX_Read_Sig && !empty;
    wr_acc  = RX_Done_Sig && (!full || rd_acc);
    ovf_evt = RX_Done_Sig && full && !rd_acc;
  end

  // Next-state: storage write, pointer advance, occupancy and sticky overflow.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;

    if (wr_acc) begin
      mem_d[wp_q] = RX_Data;
      wp_d        = wp_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rp_d = rp_q + ADDR_W'(1);
    end

    if (wr_acc && !rd_acc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // A fresh drop in the same cycle as a clear keeps the flag set.
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (RX_Ovf_Clr) begin
      ovf_d = 1'b0;
    end
  end

  // State registers; reset discards all buffered words and clears storage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Output decode straight from registered state, no added latency.
  always_comb begin
    RX_En_Sig    = !empty;
    RX_Data_Out  = empty ? '0 : mem_q[rp_q];
    RX_Count     = cnt_q;
    RX_Full_Sig  = full;
    RX_Afull_Sig = (cnt_q >= CNT_W'(AFULL_LVL));
    RX_Ovf_Sig   = ovf_q;
  end

endmodule

// File: tb/tb_rx_control_fifo.sv
// Testbench for rx_control_fifo (DEPTH=16, DATA_W=8, AFULL_LVL=14).
module tb_rx_control_fifo;

  logic       CLK;
  logic       RST;
  logic       RX_Done_Sig;
  logic [7:0] RX_Data;
  logic       RX_Read_Sig;
  logic       RX_Ovf_Clr;
  logic       RX_En_Sig;
  logic [7:0] RX_Data_Out;
  logic [4:0] RX_Count;
  logic       RX_Full_Sig;
  logic       RX_Afull_Sig;
  logic       RX_Ovf_Sig;

  rx_control_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_LVL(14)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_Done_Sig  (RX_Done_Sig),
    .RX_Data      (RX_Data),
    .RX_Read_Sig  (RX_Read_Sig),
    .RX_Ovf_Clr   (RX_Ovf_Clr),
    .RX_En_Sig    (RX_En_Sig),
    .RX_Data_Out  (RX_Data_Out),
    .RX_Count     (RX_Count),
    .RX_Full_Sig  (RX_Full_Sig),
    .RX_Afull_Sig (RX_Afull_Sig),
    .RX_Ovf_Sig   (RX_Ovf_Sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference: a plain queue of words the consumer should see, plus the flag.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic [7:0] last_pop = 8'h00;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic       en;
    logic [7:0] dout;
    int         cnt;
    logic       full;
    logic       afull;
    logic       ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. Inputs are driven just after a rising edge;
  // the head word is scoreboarded on the falling edge before the edge that
  // consumes it, and the reference state is advanced alongside.
  task automatic step(input logic rst, input logic done, input logic [7:0] data,
                      input logic rd, input logic clr);
    logic m_full, m_rd, m_wr;
    RST         = rst;
    RX_Done_Sig = done;
    RX_Data     = data;
    RX_Read_Sig = rd;
    RX_Ovf_Clr  = clr;
    @(negedge CLK);
    m_full = (mq.size() == 16);
    m_rd   = rd && (mq.size() != 0);
    m_wr   = done && (!m_full || m_rd);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_rd) begin
        chk("sb_head", int'(RX_Data_Out), int'(mq[0]));
        last_pop = mq.pop_front();
      end
      if (m_wr) mq.push_back(data);
      if (done && m_full && !m_rd) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge CLK);
    #1;
    RST = 1'b0; RX_Done_Sig = 1'b0; RX_Read_Sig = 1'b0; RX_Ovf_Clr = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_cnt"}, int'(RX_Count), mq.size());
    chk({tag, "_en"}, int'(RX_En_Sig), int'(mq.size() != 0));
    chk({tag, "_dout"}, int'(RX_Data_Out), (mq.size() != 0) ? int'(mq[0]) : 0);
    chk({tag, "_ovf"}, int'(RX_Ovf_Sig), int'(m_ovf));
  endtask

  initial begin
    // Hand-derived post-edge expectations, starting from an empty FIFO.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b1, 8'h3C, 2, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h4D, 1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h5E, 1'b1, 1'b0, 1'b1, 8'h5E, 1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};

    RST = 1'b1; RX_Done_Sig = 1'b0; RX_Data = 8'h00; RX_Read_Sig = 1'b0; RX_Ovf_Clr = 1'b0;
    @(posedge CLK); #1;
    step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("rst_en", int'(RX_En_Sig), 0);
    chk("rst_dout", int'(RX_Data_Out), 0);
    chk("rst_cnt", int'(RX_Count), 0);
    chk("rst_full", int'(RX_Full_Sig), 0);
    chk("rst_afull", int'(RX_Afull_Sig), 0);
    chk("rst_ovf", int'(RX_Ovf_Sig), 0);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, tbl[i].done, tbl[i].data, tbl[i].rd, tbl[i].clr);
      chk($sformatf("v%0d_en", i), int'(RX_En_Sig), int'(tbl[i].en));
      chk($sformatf("v%0d_dout", i), int'(RX_Data_Out), int'(tbl[i].dout));
      chk($sformatf("v%0d_cnt", i), int'(RX_Count), tbl[i].cnt);
      chk($sformatf("v%0d_full", i), int'(RX_Full_Sig), int'(tbl[i].full));
      chk($sformatf("v%0d_afull", i), int'(RX_Afull_Sig), int'(tbl[i].afull));
      chk($sformatf("v%0d_ovf", i), int'(RX_Ovf_Sig), int'(tbl[i].ovf));
    end

    // Fill 0x00..0x0F back-to-back; almost-full first rises after the 14th.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      chk($sformatf("fill%0d_cnt", i), int'(RX_Count), i + 1);
      chk($sformatf("fill%0d_afull", i), int'(RX_Afull_Sig), int'(i >= 13));
      chk($sformatf("fill%0d_full", i), int'(RX_Full_Sig), int'(i == 15));
    end
    chk("fill_head", int'(RX_Data_Out), 8'h00);

    // Overflow while full, then clear.
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    chk("ovf_set", int'(RX_Ovf_Sig), 1);
    chk("ovf_cnt", int'(RX_Count), 16);
    chk("ovf_head", int'(RX_Data_Out), 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", int'(RX_Ovf_Sig), 0);
    // Drop and clear in the same cycle: set wins.
    step(1'b0, 1'b1, 8'h66, 1'b0, 1'b1);
    chk("ovf_setwins", int'(RX_Ovf_Sig), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2", int'(RX_Ovf_Sig), 0);

    // Full with simultaneous read and write.
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    chk("frw_cnt", int'(RX_Count), 16);
    chk("frw_ovf", int'(RX_Ovf_Sig), 0);
    chk("frw_pop", int'(last_pop), 8'h00);

    // Drain: 0x01..0x0F then 0x77; dropped words never appear.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), int'(RX_Data_Out), (i < 15) ? i + 1 : 8'h77);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_last", int'(last_pop), 8'h77);
    chk_model("drained");
    chk("drained_dout0", int'(RX_Data_Out), 0);

    // 40 words streamed with continuous read across pointer wrap.
    step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) begin
      step(1'b0, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      chk_model($sformatf("strm%0d", i));
    end
    chk("strm_last", int'(last_pop), 8'hA6);
    // Reset mid-stream with traffic on the inputs.
    step(1'b1, 1'b1, 8'hF0, 1'b1, 1'b0);
    chk("mrst_en", int'(RX_En_Sig), 0);
    chk("mrst_dout", int'(RX_Data_Out), 0);
    chk("mrst_cnt", int'(RX_Count), 0);
    chk("mrst_full", int'(RX_Full_Sig), 0);
    chk("mrst_afull", int'(RX_Afull_Sig), 0);
    chk("mrst_ovf", int'(RX_Ovf_Sig), 0);
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    chk("post_en", int'(RX_En_Sig), 1);
    chk("post_dout", int'(RX_Data_Out), 8'h11);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_pop", int'(last_pop), 8'h11);
    chk_model("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_control_fifo.md
# rx_control_fifo

Parametrised receive-side buffer between the UART receiver and downstream consumer logic. Captures every word flagged by `RX_Done_Sig` into a DEPTH-entry FIFO, so back-to-back received words are never lost while the consumer is busy. Presents the head word with a valid/read handshake. Reports occupancy, almost-full (for flow control) and a sticky overflow flag.

## Interface
- `DATA_W`, 8, received word width in bits
- `DEPTH`, 16, number of FIFO entries; power of two, 2..256
- `ADDR_W`, clog2(DEPTH), pointer width; derived, not overridden
- `AFULL_LVL`, DEPTH-2, occupancy at or above which `RX_Afull_Sig` asserts; 1..DEPTH

- `CLK`  in  1  single clock; all logic on the rising edge
- `RST`  in  1  reset, synchronous, active-high
- `RX_Done_Sig`  in  1  one-cycle strobe: `RX_Data` is valid this cycle
- `RX_Data`  in  DATA_W  received word
- `RX_Read_Sig`  in  1  consumer pops the head word this cycle
- `RX_Ovf_Clr`  in  1  clears the sticky overflow flag
- `RX_En_Sig`  out  1  head word valid (FIFO not empty)
- `RX_Data_Out`  out  DATA_W  head word; 0 when empty
- `RX_Count`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `RX_Full_Sig`  out  1  `RX_Count` == DEPTH
- `RX_Afull_Sig`  out  1  `RX_Count` >= AFULL_LVL
- `RX_Ovf_Sig`  out  1  sticky: a word was dropped because the FIFO was full

## Operation
- Storage: DEPTH x DATA_W register array, write pointer `wp` and read pointer `rp` (ADDR_W bits each), occupancy counter `cnt` (ADDR_W+1 bits). Pointers wrap modulo DEPTH naturally.
- Write: `RX_Done_Sig`=1 and (not full, or read accepted the same cycle) -> `mem[wp]` <= `RX_Data`, `wp` += 1.
- Read accepted: `RX_Read_Sig`=1 and `cnt`!=0 -> `rp` += 1. A read while empty is ignored; no state change and no error flag.
- Occupancy update from accepted write (w) and accepted read (r):
  - w and not r: +1
  - r and not w: -1
  - both or neither: unchanged
- Full with simultaneous read and write: both accepted, `cnt` stays DEPTH, no overflow.
- Empty with simultaneous read and write: only the write is accepted (no bypass); `cnt` becomes 1.
- Overflow: `RX_Done_Sig`=1, full, no read -> word dropped, `RX_Ovf_Sig` <= 1. Memory and pointers are unchanged.
- Overflow clear: `RX_Ovf_Clr`=1 clears the flag. If a new overflow happens in the same cycle, set wins.
- `RX_Data_Out` = `mem[rp]` when `cnt`!=0, else 0 (combinational mux from registered state).
- `RX_En_Sig`, `RX_Full_Sig` and `RX_Afull_Sig` decode combinationally from the registered `cnt`; no extra latency.

## Timing
- Reset (`RST`=1 at an edge): `wp`=`rp`=0, `cnt`=0, memory cleared to 0, `RX_Ovf_Sig`=0.
- Reset output values: `RX_En_Sig`=0, `RX_Data_Out`=0, `RX_Count`=0, `RX_Full_Sig`=0, `RX_Afull_Sig`=0 (AFULL_LVL>=1), `RX_Ovf_Sig`=0.
- Reset overrides all inputs in the same cycle. A reset mid-stream discards all buffered words.
- Write latency: `RX_Done_Sig` in cycle N -> word counted from cycle N+1. Into an empty FIFO, `RX_En_Sig`=1 and `RX_Data_Out`=word in N+1.
- Read: `RX_Read_Sig` with `RX_En_Sig`=1 in cycle M -> next head word, or empty (0), visible in M+1.
- Consumer may hold `RX_Read_Sig` high continuously; sustained throughput is 1 word/cycle in each direction.
- `RX_Done_Sig` may assert on consecutive cycles.

## Test plan
- Reset, then write 0xA5 -> next cycle: `RX_En_Sig`=1, `RX_Data_Out`=0xA5, `RX_Count`=1. Read -> next cycle: `RX_En_Sig`=0, `RX_Data_Out`=0.
- DEPTH=16: write 0x00..0x0F back-to-back -> `RX_Full_Sig`=1, `RX_Count`=16; `RX_Afull_Sig` first high after the 14th write. Drain -> words read out 0x00..0x0F in order.
- Full FIFO: write 0x55 with no read -> `RX_Ovf_Sig`=1, `RX_Count`=16, 0x55 never read out. Then pulse `RX_Ovf_Clr` -> flag 0 next cycle.
- Full FIFO: write 0x77 and read in the same cycle -> `RX_Count`=16, `RX_Ovf_Sig`=0, 0x77 is the last word read.
- Empty FIFO: read + write 0x3C in the same cycle -> `RX_Count`=1, head word 0x3C. A read alone while empty -> no change.
- 40 words streamed with continuous read across pointer wrap, then `RST` asserted mid-stream -> all outputs 0 the next cycle; a subsequent write of 0x11 reads back as 0x11.
